// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings and the baud divisor
// calculation used by both the transmitter and the receiver.
package uart_tx_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Clock cycles per bit; integer division so the receiver computes the
  // identical count and both ends agree cycle-for-cycle.
  function automatic int calc_baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register. pi_data/pi_flag
// follow the receiver's po_data/po_flag strobe convention so the two can be
// chained for echo. tx is registered and lags the FSM by one cycle; tx_done
// is delayed to line up with the end of the stop bit as seen on tx.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ovf
);

  localparam int          BAUD_CNT_MAX = calc_baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);

  logic [1:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  hold_data;
  logic        hold_valid;
  logic        stop_end_p0;

  logic        bit_end;
  logic        consume;
  logic        accept;
  logic        drop;

  // Bit boundary, hold consumption and strobe acceptance
  always_comb begin
    bit_end = (state != IDLE) && (baud_cnt == BAUD_LAST);
    consume = hold_valid && ((state == IDLE) || ((state == STOP) && bit_end));
    accept  = pi_flag && (!hold_valid || consume);
    drop    = pi_flag && !accept;
  end

  // Holding register occupancy; a strobe on the consume cycle refills it
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
    end else if (consume) begin
      hold_valid <= 1'b0;
    end
  end

  // Holding register data, only meaningful while hold_valid is set
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      hold_data <= pi_data;
    end
  end

  // Frame sequencer with baud and bit counters
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= 16'd0;
          bit_cnt  <= 3'd0;
          if (consume) begin
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            state    <= consume ? START : IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Shifter: loaded on consume, shifted right at the end of each data bit
  always_ff @(posedge sys_clk) begin
    if (consume) begin
      shift <= hold_data;
    end else if ((state == DATA) && bit_end) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  // Registered line driver and event pulses
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx          <= 1'b1;
      stop_end_p0 <= 1'b0;
      tx_done     <= 1'b0;
      tx_ovf      <= 1'b0;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        default: tx <= 1'b1;
      endcase
      stop_end_p0 <= (state == STOP) && bit_end;
      tx_done     <= stop_end_p0;
      tx_ovf      <= drop;
    end
  end

  // Status flags derived from registers only
  always_comb begin
    tx_ready = ~hold_valid;
    tx_busy  = (state != IDLE) | hold_valid;
  end

endmodule
